// File: rtl/snake_game_ctrl.sv
// Game sequencer for the snake: button arbitration into a reversal-safe
// 2-entry direction queue, move tick generation, game FSM and apple handshake.
module snake_game_ctrl #(
  parameter int TICK_DIV = 4000000,
  parameter int MAX_LEN  = 16,
  parameter int SCORE_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       l,
  input  logic                       r,
  input  logic                       u,
  input  logic                       d,
  input  logic                       start,
  input  logic                       hit_border,
  input  logic                       hit_self,
  input  logic                       apple_eaten,
  input  logic                       apple_ack,
  output logic                       apple_req,
  output logic                       move,
  output logic [3:0]                 direction,
  output logic [$clog2(MAX_LEN):0]   snake_len,
  output logic [SCORE_W-1:0]         score,
  output logic                       running,
  output logic                       game_over,
  output logic [1:0]                 state
);

  localparam int LEN_W = $clog2(MAX_LEN) + 1;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    RUN        = 2'b01,
    WAIT_APPLE = 2'b10,
    OVER       = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         dir_q, dir_d;
  logic [3:0]         qe0_q, qe0_d, qe1_q, qe1_d;
  logic [1:0]         qcnt_q, qcnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               move_q, move_d;
  logic               req_q, req_d;
  logic               running_q, running_d;
  logic               over_q, over_d;
  logic               start_q, start_d;
  logic [3:0]         btn_q, btn_d;

  logic [3:0] rise, win, ref_dir, ref_opp;
  logic       start_edge, active, tick, collide;

  always_comb begin
    btn_d      = {d, u, r, l};
    start_d    = start;
    rise       = btn_d & ~btn_q;
    start_edge = start & ~start_q;
    active     = (state_q == RUN) || (state_q == WAIT_APPLE);
    tick       = (cnt_q == CNT_W'(TICK_DIV - 1));
    collide    = hit_border | hit_self;

    // Bit order {d,u,r,l} matches the one-hot direction code, so the lowest set bit wins
    win = 4'b0000;
    if (rise[0])      win = 4'b0001;
    else if (rise[1]) win = 4'b0010;
    else if (rise[2]) win = 4'b0100;
    else if (rise[3]) win = 4'b1000;

    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    qe0_d   = qe0_q;
    qe1_d   = qe1_q;
    qcnt_d  = qcnt_q;
    len_d   = len_q;
    score_d = score_q;
    move_d  = 1'b0;
    req_d   = req_q;
    ref_dir = dir_q;
    ref_opp = 4'b0000;

    if (!active) begin
      if (start_edge) begin
        state_d = RUN;
        cnt_d   = '0;
        qcnt_d  = 2'd0;
        qe0_d   = 4'b0000;
        qe1_d   = 4'b0000;
        score_d = '0;
        len_d   = LEN_W'(1);
        dir_d   = DIR_RIGHT;
      end
    end else if (collide) begin
      state_d = OVER;
      req_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        move_d = 1'b1;
        if (qcnt_q != 2'd0) begin
          dir_d  = qe0_q;
          qe0_d  = qe1_q;
          qcnt_d = qcnt_q - 2'd1;
        end
      end

      // A push in the same cycle as a pop is judged against the post-pop queue
      ref_dir = (qcnt_d == 2'd0) ? dir_d : ((qcnt_d == 2'd1) ? qe0_d : qe1_d);
      ref_opp = {ref_dir[2], ref_dir[3], ref_dir[0], ref_dir[1]};
      if ((win != 4'b0000) && (qcnt_d != 2'd2) && (win != ref_dir) && (win != ref_opp)) begin
        if (qcnt_d == 2'd0) qe0_d = win;
        else                qe1_d = win;
        qcnt_d = qcnt_d + 2'd1;
      end

      if (state_q == RUN) begin
        if (apple_eaten) begin
          if (score_q != '1)               score_d = score_q + 1'b1;
          if (len_q < LEN_W'(MAX_LEN))     len_d   = len_q + 1'b1;
          req_d   = 1'b1;
          state_d = WAIT_APPLE;
        end
      end else if (apple_ack) begin
        req_d   = 1'b0;
        state_d = RUN;
      end
    end

    running_d = (state_d == RUN) || (state_d == WAIT_APPLE);
    over_d    = (state_d == OVER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_q     <= DIR_RIGHT;
      qe0_q     <= 4'b0000;
      qe1_q     <= 4'b0000;
      qcnt_q    <= 2'd0;
      len_q     <= LEN_W'(1);
      score_q   <= '0;
      move_q    <= 1'b0;
      req_q     <= 1'b0;
      running_q <= 1'b0;
      over_q    <= 1'b0;
      start_q   <= 1'b0;
      btn_q     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      qe0_q     <= qe0_d;
      qe1_q     <= qe1_d;
      qcnt_q    <= qcnt_d;
      len_q     <= len_d;
      score_q   <= score_d;
      move_q    <= move_d;
      req_q     <= req_d;
      running_q <= running_d;
      over_q    <= over_d;
      start_q   <= start_d;
      btn_q     <= btn_d;
    end
  end

  assign state     = state_q;
  assign direction = dir_q;
  assign snake_len = len_q;
  assign score     = score_q;
  assign move      = move_q;
  assign apple_req = req_q;
  assign running   = running_q;
  assign game_over = over_q;

endmodule
